// File: rtl/cfg_dprio_pkg.sv
// Shared definitions for the DPRIO status-capture block: handshake FSM
// state encodings and the stale-counter type.
package cfg_dprio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_ACK_HI  = 2'b10
    } hs_state_e;

    localparam int unsigned STALE_CNT_W = 16;

    typedef logic [STALE_CNT_W-1:0] stale_cnt_t;

endpackage

// File: rtl/cfg_dprio_bitsync_sr.sv
// Single-bit shift-register synchronizer with synchronous active-high reset.
// The output is the last stage; the first stage may go metastable.
module cfg_dprio_bitsync_sr #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge value of its neighbour; blocking ones would collapse
        // the chain into a single stage.
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cfg_dprio_status_capture.sv
// Status-word capture with a write_en/write_en_ack handshake, sticky
// per-bit change tracking, a stale-data watchdog and a registered irq.
module cfg_dprio_status_capture
    import cfg_dprio_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int STALE_CYCLES = 1024,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] stat_data_in,
    input  logic                  clr_sticky,
    input  logic                  irq_en,
    output logic                  write_en_ack,
    output logic [DATA_WIDTH-1:0] stat_data_out,
    output logic                  stat_valid,
    output logic [DATA_WIDTH-1:0] stat_change,
    output logic                  stat_stale,
    output logic                  irq
);

    localparam stale_cnt_t STALE_MAX = stale_cnt_t'(STALE_CYCLES);

    logic                  we_s;
    hs_state_e             state_q, state_d;
    logic                  capture;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] change_q, change_d;
    logic                  valid_q, valid_d;
    logic                  ack_q, ack_d;
    logic                  irq_q, irq_d;
    stale_cnt_t            cnt_q, cnt_d;
    logic                  stale;

    cfg_dprio_bitsync_sr #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_we_sync (
        .clk(clk),
        .rst(rst),
        .d_i(write_en),
        .q_o(we_s)
    );

    // Handshake FSM next-state; stray encodings recover to IDLE.
    always_comb begin
        // NOTE: state_d is assigned before the case so every path drives it
        // and no latch is inferred.
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:    state_d = we_s ? ST_CAPTURE : ST_IDLE;
            ST_CAPTURE: state_d = ST_ACK_HI;
            ST_ACK_HI:  state_d = we_s ? ST_ACK_HI : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign capture = (state_q == ST_CAPTURE);
    assign stale   = (cnt_q == STALE_MAX);

    // Capture datapath, sticky change mask, stale counter and irq next-state.
    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        // A clear pulse wipes history, but a coincident capture still ORs in
        // its own differences so no fresh change is lost.
        change_d = clr_sticky ? '0 : change_q;
        if (capture) begin
            data_d  = stat_data_in;
            valid_d = 1'b1;
            if (valid_q) begin
                change_d = change_d | (stat_data_in ^ data_q);
            end
        end

        if (capture) begin
            cnt_d = '0;
        end else if (stale) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + stale_cnt_t'(1);
        end

        ack_d = (state_d == ST_ACK_HI);
        irq_d = irq_en & ((|change_q) | stale);
    end

    // All state registers share one synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            change_q <= '0;
            valid_q  <= 1'b0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            change_q <= change_d;
            valid_q  <= valid_d;
            ack_q    <= ack_d;
            irq_q    <= irq_d;
            cnt_q    <= cnt_d;
        end
    end

    assign write_en_ack  = ack_q;
    assign stat_data_out = data_q;
    assign stat_valid    = valid_q;
    assign stat_change   = change_q;
    assign stat_stale    = stale;
    assign irq           = irq_q;

endmodule
